// File: rtl/reg_file_pkg.sv
// Shared register-identifier encoding for the 64-bit core: R0-R31, SP, BP, FLAGS, PC, ZERO.
// Ids above ZERO are invalid and never touch state.
package registers;

  typedef enum logic [7:0] {
    REG_R0    = 8'd0,
    REG_R31   = 8'd31,
    REG_SP    = 8'd32,
    REG_BP    = 8'd33,
    REG_FLAGS = 8'd34,
    REG_PC    = 8'd35,
    REG_ZERO  = 8'd36
  } register_t;

  localparam int unsigned    NUM_STORED_REGS = 36;
  localparam logic [7:0]     REG_ZERO_ID     = 8'd36;

  // True for any legal encoding, including ZERO.
  function automatic logic reg_valid(register_t r);
    return r <= REG_ZERO;
  endfunction

  // True only for ids that own storage and a busy bit.
  function automatic logic reg_stored(logic [7:0] id);
    return id < 8'(NUM_STORED_REGS);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// One pending-write bit per stored register; issue sets, write-back clears, issue wins a tie.
// Write-back clears are bypassed so stalls release in the same cycle as the result.
module reg_scoreboard
  import registers::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid,
  input  logic [7:0] iss_addr,
  output logic       iss_ready,
  input  logic       wb_valid,
  input  logic [7:0] wb_addr,
  input  logic [7:0] rd_a_addr,
  input  logic [7:0] rd_b_addr,
  output logic       rd_a_busy,
  output logic       rd_b_busy
);

  logic [NUM_STORED_REGS-1:0] r_busy;
  logic                       w_iss_busy;
  logic                       w_iss_fire;

  always_comb begin
    w_iss_busy = 1'b0;
    rd_a_busy  = 1'b0;
    rd_b_busy  = 1'b0;
    if (reg_stored(iss_addr))
      w_iss_busy = r_busy[iss_addr[5:0]];
    if (reg_stored(rd_a_addr))
      rd_a_busy = r_busy[rd_a_addr[5:0]] & ~(wb_valid && wb_addr == rd_a_addr);
    if (reg_stored(rd_b_addr))
      rd_b_busy = r_busy[rd_b_addr[5:0]] & ~(wb_valid && wb_addr == rd_b_addr);
  end

  assign iss_ready  = ~w_iss_busy | (wb_valid && wb_addr == iss_addr);
  assign w_iss_fire = iss_valid & iss_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_STORED_REGS; i++) begin
        if (w_iss_fire && iss_addr == 8'(i))
          r_busy[i] <= 1'b1;
        else if (wb_valid && wb_addr == 8'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-back bypass,
// one write-back port, and a pending-write scoreboard for decode stalls.
module reg_file
  import registers::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] SP_RESET = '0,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rd_a_addr,
  output logic [XLEN-1:0] rd_a_data,
  output logic            rd_a_busy,
  input  logic [7:0]      rd_b_addr,
  output logic [XLEN-1:0] rd_b_data,
  output logic            rd_b_busy,
  input  logic            iss_valid,
  input  logic [7:0]      iss_addr,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [7:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            bad_addr
);

  logic [NUM_STORED_REGS-1:0][XLEN-1:0] r_regs;
  logic                                 r_bad;
  logic                                 w_bad;

  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    if (reg_stored(rd_a_addr))
      rd_a_data = (wb_valid && wb_addr == rd_a_addr) ? wb_data : r_regs[rd_a_addr[5:0]];
    if (reg_stored(rd_b_addr))
      rd_b_data = (wb_valid && wb_addr == rd_b_addr) ? wb_data : r_regs[rd_b_addr[5:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STORED_REGS; i++)
        r_regs[i] <= (8'(i) == REG_SP) ? SP_RESET :
                     (8'(i) == REG_PC) ? PC_RESET : '0;
    end else if (wb_valid && reg_stored(wb_addr)) begin
      r_regs[wb_addr[5:0]] <= wb_data;
    end
  end

  // Read ports are always considered active; iss/wb only when strobed.
  assign w_bad = ~reg_valid(register_t'(rd_a_addr)) |
                 ~reg_valid(register_t'(rd_b_addr)) |
                 (iss_valid & ~reg_valid(register_t'(iss_addr))) |
                 (wb_valid  & ~reg_valid(register_t'(wb_addr)));

  always_ff @(posedge clk) begin
    if (rst) r_bad <= 1'b0;
    else     r_bad <= w_bad;
  end

  assign bad_addr = r_bad;

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_busy (rd_a_busy),
    .rd_b_busy (rd_b_busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one table row per cycle with hand-computed outputs,
// then sequences for bad_addr latency and mid-operation reset.
module tb_reg_file;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rd_a_addr, rd_b_addr, iss_addr, wb_addr;
  logic [XLEN-1:0] rd_a_data, rd_b_data, wb_data;
  logic            rd_a_busy, rd_b_busy, iss_valid, iss_ready, wb_valid, bad_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file #(
    .XLEN     (XLEN),
    .SP_RESET (64'h1000),
    .PC_RESET (64'h8000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (rd_a_addr),
    .rd_a_data (rd_a_data),
    .rd_a_busy (rd_a_busy),
    .rd_b_addr (rd_b_addr),
    .rd_b_data (rd_b_data),
    .rd_b_busy (rd_b_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .bad_addr  (bad_addr)
  );

  typedef struct {
    logic [7:0]  ra, rb;
    logic        iv;
    logic [7:0]  ia;
    logic        wv;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic [63:0] exp_ad;
    logic        exp_ab;
    logic [63:0] exp_bd;
    logic        exp_bb;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ra, input logic [7:0] rb, input logic iv,
                       input logic [7:0] ia, input logic wv, input logic [7:0] wa,
                       input logic [63:0] wd);
    rd_a_addr = ra; rd_b_addr = rb; iss_valid = iv; iss_addr = ia;
    wb_valid  = wv; wb_addr   = wa; wb_data   = wd;
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1-2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ra     rb     iv ia     wv wa     wd            a_data        ab b_data        bb rdy
    vecs[0]  = '{8'd32, 8'd35, 0, 8'd0,  0, 8'd0,  64'h0,        64'h1000,     0, 64'h8000,     0, 1};
    vecs[1]  = '{8'd5,  8'd3,  0, 8'd0,  1, 8'd3,  64'hDEADBEEF, 64'h0,        0, 64'hDEADBEEF, 0, 1};
    vecs[2]  = '{8'd3,  8'd36, 0, 8'd0,  0, 8'd0,  64'h0,        64'hDEADBEEF, 0, 64'h0,        0, 1};
    vecs[3]  = '{8'd36, 8'd36, 1, 8'd36, 1, 8'd36, 64'h55,       64'h0,        0, 64'h0,        0, 1};
    vecs[4]  = '{8'd36, 8'd36, 0, 8'd36, 0, 8'd0,  64'h0,        64'h0,        0, 64'h0,        0, 1};
    vecs[5]  = '{8'd7,  8'd0,  1, 8'd7,  0, 8'd0,  64'h0,        64'h0,        0, 64'h0,        0, 1};
    vecs[6]  = '{8'd7,  8'd0,  1, 8'd7,  0, 8'd0,  64'h0,        64'h0,        1, 64'h0,        0, 0};
    vecs[7]  = '{8'd7,  8'd0,  1, 8'd7,  1, 8'd7,  64'h42,       64'h42,       0, 64'h0,        0, 1};
    vecs[8]  = '{8'd7,  8'd0,  0, 8'd7,  0, 8'd0,  64'h0,        64'h42,       1, 64'h0,        0, 0};
    vecs[9]  = '{8'd7,  8'd0,  0, 8'd7,  1, 8'd7,  64'h43,       64'h43,       0, 64'h0,        0, 1};
    vecs[10] = '{8'd7,  8'd9,  0, 8'd7,  0, 8'd0,  64'h0,        64'h43,       0, 64'h0,        0, 1};
    vecs[11] = '{8'd7,  8'd9,  1, 8'd9,  0, 8'd0,  64'h0,        64'h43,       0, 64'h0,        0, 1};
    vecs[12] = '{8'd7,  8'd9,  1, 8'd9,  1, 8'd9,  64'h99,       64'h43,       0, 64'h99,       0, 1};
    vecs[13] = '{8'd7,  8'd9,  0, 8'd9,  0, 8'd0,  64'h0,        64'h43,       0, 64'h99,       1, 0};
    vecs[14] = '{8'd10, 8'd9,  0, 8'd0,  1, 8'd10, 64'h10,       64'h10,       0, 64'h99,       1, 1};
    vecs[15] = '{8'd10, 8'd40, 0, 8'd0,  0, 8'd0,  64'h0,        64'h10,       0, 64'h0,        0, 1};

    rst = 1'b1;
    drive(8'd0, 8'd0, 0, 8'd0, 0, 8'd0, 64'h0);
    tick(); tick();
    rst = 1'b0;
    drive(8'd5, 8'd34, 0, 8'd0, 0, 8'd0, 64'h0);
    #1;
    chk("reset_r5",       rd_a_data, 64'h0);
    chk("reset_r5_busy",  {63'b0, rd_a_busy}, 64'h0);
    chk("reset_flags",    rd_b_data, 64'h0);
    chk("reset_bad",      {63'b0, bad_addr}, 64'h0);
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].iv, vecs[i].ia, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      #1;
      chk($sformatf("v%0d_a_data", i), rd_a_data, vecs[i].exp_ad);
      chk($sformatf("v%0d_a_busy", i), {63'b0, rd_a_busy}, {63'b0, vecs[i].exp_ab});
      chk($sformatf("v%0d_b_data", i), rd_b_data, vecs[i].exp_bd);
      chk($sformatf("v%0d_b_busy", i), {63'b0, rd_b_busy}, {63'b0, vecs[i].exp_bb});
      chk($sformatf("v%0d_iss_rdy", i), {63'b0, iss_ready}, {63'b0, vecs[i].exp_rdy});
      tick();
    end

    // vecs[15] put 40 on port B; flag shows one cycle later, then clears.
    drive(8'd0, 8'd0, 0, 8'd0, 0, 8'd0, 64'h0);
    #1;
    chk("bad_rd_b", {63'b0, bad_addr}, 64'h1);
    tick();
    chk("bad_clear", {63'b0, bad_addr}, 64'h0);

    // Invalid iss id: ready, no effect, flagged next cycle.
    drive(8'd0, 8'd0, 1, 8'd200, 0, 8'd0, 64'h0);
    #1;
    chk("iss_invalid_rdy", {63'b0, iss_ready}, 64'h1);
    tick();
    chk("bad_iss", {63'b0, bad_addr}, 64'h1);

    // Inactive invalid iss id is not flagged; invalid wb write is dropped and flagged.
    drive(8'd0, 8'd0, 0, 8'd200, 1, 8'd37, 64'hFFFF);
    tick();
    chk("bad_wb", {63'b0, bad_addr}, 64'h1);
    drive(8'd0, 8'd0, 0, 8'd200, 0, 8'd0, 64'h0);
    tick();
    chk("bad_iss_inactive", {63'b0, bad_addr}, 64'h0);

    // Mid-operation reset: R2 written then made busy; reset beats same-cycle wb/iss.
    drive(8'd2, 8'd0, 0, 8'd0, 1, 8'd2, 64'h77);
    tick();
    drive(8'd2, 8'd0, 1, 8'd2, 0, 8'd0, 64'h0);
    tick();
    drive(8'd2, 8'd32, 0, 8'd2, 0, 8'd0, 64'h0);
    #1;
    chk("r2_busy_pre", {63'b0, rd_a_busy}, 64'h1);
    chk("r2_data_pre", rd_a_data, 64'h77);
    rst = 1'b1;
    drive(8'd2, 8'd40, 1, 8'd5, 1, 8'd2, 64'h88);
    tick();
    rst = 1'b0;
    drive(8'd2, 8'd5, 0, 8'd0, 0, 8'd0, 64'h0);
    #1;
    chk("rst_r2_busy", {63'b0, rd_a_busy}, 64'h0);
    chk("rst_r2_data", rd_a_data, 64'h0);
    chk("rst_r5_busy", {63'b0, rd_b_busy}, 64'h0);
    chk("rst_bad",     {63'b0, bad_addr}, 64'h0);
    drive(8'd32, 8'd35, 0, 8'd0, 0, 8'd0, 64'h0);
    #1;
    chk("rst_sp", rd_a_data, 64'h1000);
    chk("rst_pc", rd_b_data, 64'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
